// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS32 core: merges stage stall requests, sequences
// exception entry / ERET return (freeze, drain bus cycles, one-cycle flush), counts stalls.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter logic [31:0] ERET_CODE  = 32'h0000000e,
    parameter int unsigned MAX_STALL  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    localparam int unsigned WD_W = $clog2(MAX_STALL + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE,
        EXC_WAIT,
        FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     new_pc_q, new_pc_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic            bus_busy;
    logic            exc_req;

    assign bus_busy = stallreq_if | stallreq_mem;
    assign exc_req  = (excepttype_i != '0);

    // Stall/flush respond in the same cycle as the requests; only state and new_pc are held.
    always_comb begin
        state_d  = state_q;
        new_pc_d = new_pc_q;
        stall    = STALL_NONE;
        flush    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (exc_req) begin
                    stall    = STALL_ALL;
                    new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                    state_d  = bus_busy ? EXC_WAIT : FLUSH;
                end else if (stallreq_mem) begin
                    stall = STALL_MEM;
                end else if (stallreq_ex) begin
                    stall = STALL_EX;
                end else if (stallreq_id || stallreq_if) begin
                    stall = STALL_ID;
                end
            end
            EXC_WAIT: begin
                stall = STALL_ALL;
                if (!bus_busy) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            stall = STALL_NONE;
            flush = 1'b0;
        end
    end

    // Watchdog counter saturates at MAX_STALL; the timeout flag is sticky until reset.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        wd_d           = '0;
        timeout_d      = timeout_q;
        if (stall[0]) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
            wd_d           = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            if (wd_d == WD_MAX) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            new_pc_q       <= '0;
            stall_cycles_q <= '0;
            wd_q           <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            new_pc_q       <= new_pc_d;
            stall_cycles_q <= stall_cycles_d;
            wd_q           <= wd_d;
            timeout_q      <= timeout_d;
        end
    end

    assign new_pc        = new_pc_q;
    assign stall_cycles  = stall_cycles_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expectations from a
// behavioural model, a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    localparam logic [31:0] VEC   = 32'h00000020;
    localparam logic [31:0] ERET  = 32'h0000000e;
    localparam int          MAXST = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    pipe_ctrl #(
        .EXC_VECTOR(VEC),
        .ERET_CODE (ERET),
        .MAX_STALL (MAXST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] sc;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: an exception is "pending" until both buses are quiet, then the
    // following cycle is the flush cycle. Counters follow the stall[0] history directly.
    bit          m_pending, m_flushnow, m_to;
    logic [31:0] m_pc, m_sc;
    int          m_run;

    function automatic void model_reset();
        m_pending = 0; m_flushnow = 0; m_to = 0;
        m_pc = '0; m_sc = '0; m_run = 0;
    endfunction

    task automatic cyc(input bit r, input bit fi, input bit fd, input bit fe, input bit fm,
                       input logic [31:0] exc, input logic [31:0] epc);
        exp_t e;
        bit   quiet;
        @(posedge clk);
        #1;
        rst = r; stallreq_if = fi; stallreq_id = fd; stallreq_ex = fe; stallreq_mem = fm;
        excepttype_i = exc; cp0_epc_i = epc;
        quiet   = !fi && !fm;
        e.pc    = m_pc;
        e.sc    = m_sc;
        e.to    = m_to;
        e.flush = 0;
        e.stall = 6'b000000;
        if (r) begin
            exp_q.push_back(e);
            model_reset();
            return;
        end
        if (m_flushnow) begin
            e.flush = 1;
            m_flushnow = 0;
        end else if (m_pending) begin
            e.stall = 6'b111111;
            if (quiet) begin m_pending = 0; m_flushnow = 1; end
        end else if (exc != 0) begin
            e.stall = 6'b111111;
            m_pc = (exc == ERET) ? epc : VEC;
            if (quiet) m_flushnow = 1; else m_pending = 1;
        end else if (fm) e.stall = 6'b011111;
        else if (fe)     e.stall = 6'b001111;
        else if (fd || fi) e.stall = 6'b000111;
        exp_q.push_back(e);
        if (e.stall[0]) begin
            m_sc++;
            if (m_run < MAXST) m_run++;
            if (m_run == MAXST) m_to = 1;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall",         {26'd0, stall},  {26'd0, e.stall});
            chk("flush",         {31'd0, flush},  {31'd0, e.flush});
            chk("new_pc",        new_pc,          e.pc);
            chk("stall_cycles",  stall_cycles,    e.sc);
            chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, e.to});
        end
    end

    initial begin
        logic [31:0] exc, epc;
        rst = 1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excepttype_i = '0; cp0_epc_i = '0;
        model_reset();

        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
        // 1: load-use stall for 3 cycles
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // 2: stall priority
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // 3: exception with idle buses, ignored request during flush, back-to-back
        cyc(0, 0, 0, 0, 0, 32'h8, 32'h1234);
        cyc(0, 0, 0, 0, 0, 32'h8, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, ERET, 32'h0000_4444);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 32'h4, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // 4: ERET while data bus busy for 4 cycles
        cyc(0, 0, 0, 0, 1, ERET, 32'hbfc00100);
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // 5: watchdog at exactly MAX_STALL, sticky, then cleared by reset
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (MAXST - 1) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // 6: reset during EXC_WAIT abandons the sequence
        cyc(0, 1, 0, 0, 0, 32'h10, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        // reset during FLUSH
        cyc(0, 0, 0, 0, 0, 32'h10, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++) begin
            exc = 0;
            epc = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: exc = 32'h8;
                    1: exc = ERET;
                    default: exc = $urandom | 32'h1;
                endcase
            end
            cyc($urandom_range(0, 59) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, exc, epc);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
